// File: rtl/uart_cmd_rcv.sv
// Assembles UART bytes into 16-bit commands and returns one-byte responses.
// Optional macro CMD_CHKSUM_EN adds a third checksum byte, ~(hi+lo), to each frame.
module uart_cmd_rcv #(
    parameter int TIMEOUT = 20000,
    parameter int CNT_W   = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rx_rdy,
    input  logic [7:0]  i_rx_data,
    output logic        o_clr_rx_rdy,
    output logic [15:0] o_cmd,
    output logic        o_cmd_rdy,
    input  logic        i_clr_cmd_rdy,
    input  logic        i_snd_resp,
    input  logic [7:0]  i_resp,
    output logic        o_trmt,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_done,
    output logic        o_resp_sent,
    output logic        o_frm_err
);

    typedef enum logic [1:0] {
        WAIT_HI,
        WAIT_LO,
        WAIT_CK
    } rx_state_t;

    typedef enum logic {
        TX_IDLE,
        TX_BUSY
    } tx_state_t;

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT - 1);

    rx_state_t         r_rx_state;
    tx_state_t         r_tx_state;
    logic [7:0]        r_hi;
    logic [CNT_W-1:0]  r_timer;
    logic [15:0]       r_cmd;
    logic              r_cmd_rdy;
    logic              r_frm_err;
    logic              r_trmt;
    logic [7:0]        r_tx_data;
    logic              r_resp_sent;
    logic              w_timeout;

`ifdef CMD_CHKSUM_EN
    logic [7:0]        r_lo;
    logic [7:0]        w_sum;
    logic [7:0]        w_chk;

    assign w_sum = r_hi + r_lo;
    assign w_chk = ~w_sum;
`endif

    // Every byte is consumed in the cycle it is offered, whatever the state.
    assign o_clr_rx_rdy = i_rx_rdy;
    assign w_timeout    = (r_timer == TERM_CNT);

    assign o_cmd       = r_cmd;
    assign o_cmd_rdy   = r_cmd_rdy;
    assign o_frm_err   = r_frm_err;
    assign o_trmt      = r_trmt;
    assign o_tx_data   = r_tx_data;
    assign o_resp_sent = r_resp_sent;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rx_state <= WAIT_HI;
            r_hi       <= '0;
            r_timer    <= '0;
            r_cmd      <= '0;
            r_cmd_rdy  <= 1'b0;
            r_frm_err  <= 1'b0;
`ifdef CMD_CHKSUM_EN
            r_lo       <= '0;
`endif
        end else begin
            r_frm_err <= 1'b0;
            // Later assignments below (frame completion) override this clear.
            if (i_clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
            end
            case (r_rx_state)
                WAIT_HI: begin
                    if (i_rx_rdy) begin
                        r_hi       <= i_rx_data;
                        r_timer    <= '0;
                        r_cmd_rdy  <= 1'b0;
                        r_rx_state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    r_timer <= r_timer + 1'b1;
                    if (i_rx_rdy) begin
`ifdef CMD_CHKSUM_EN
                        r_lo       <= i_rx_data;
                        r_timer    <= '0;
                        r_rx_state <= WAIT_CK;
`else
                        r_cmd      <= {r_hi, i_rx_data};
                        r_cmd_rdy  <= 1'b1;
                        r_rx_state <= WAIT_HI;
`endif
                    end else if (w_timeout) begin
                        r_frm_err  <= 1'b1;
                        r_hi       <= '0;
                        r_rx_state <= WAIT_HI;
                    end
                end
`ifdef CMD_CHKSUM_EN
                WAIT_CK: begin
                    r_timer <= r_timer + 1'b1;
                    if (i_rx_rdy) begin
                        if (i_rx_data == w_chk) begin
                            r_cmd     <= {r_hi, r_lo};
                            r_cmd_rdy <= 1'b1;
                        end else begin
                            r_frm_err <= 1'b1;
                        end
                        r_hi       <= '0;
                        r_lo       <= '0;
                        r_rx_state <= WAIT_HI;
                    end else if (w_timeout) begin
                        r_frm_err  <= 1'b1;
                        r_hi       <= '0;
                        r_lo       <= '0;
                        r_rx_state <= WAIT_HI;
                    end
                end
`endif
                default: begin
                    r_rx_state <= WAIT_HI;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tx_state  <= TX_IDLE;
            r_trmt      <= 1'b0;
            r_tx_data   <= '0;
            r_resp_sent <= 1'b0;
        end else begin
            r_trmt <= 1'b0;
            case (r_tx_state)
                TX_IDLE: begin
                    if (i_snd_resp) begin
                        r_tx_data   <= i_resp;
                        r_resp_sent <= 1'b0;
                        r_trmt      <= 1'b1;
                        r_tx_state  <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    if (i_tx_done) begin
                        r_resp_sent <= 1'b1;
                        r_tx_state  <= TX_IDLE;
                    end
                end
                default: begin
                    r_tx_state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Scoreboard bench for uart_cmd_rcv; define CMD_CHKSUM_EN to exercise three-byte frames.
module tb_uart_cmd_rcv;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;

    logic        clk = 1'b0;
    logic        rstN;
    logic        rxRdy;
    logic [7:0]  rxData;
    logic        clrRxRdy;
    logic [15:0] cmd;
    logic        cmdRdy;
    logic        clrCmdRdy;
    logic        sndResp;
    logic [7:0]  resp;
    logic        trmt;
    logic [7:0]  txData;
    logic        txDone;
    logic        respSent;
    logic        frmErr;

    int checks = 0;
    int errors = 0;

    logic [15:0] cmdQ[$];
    logic [15:0] frmQ[$];
    logic [7:0]  txQ[$];
    logic [7:0]  sentQ[$];

    logic prevRdy  = 1'b0;
    logic prevSent = 1'b0;

    uart_cmd_rcv #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_rx_rdy     (rxRdy),
        .i_rx_data    (rxData),
        .o_clr_rx_rdy (clrRxRdy),
        .o_cmd        (cmd),
        .o_cmd_rdy    (cmdRdy),
        .i_clr_cmd_rdy(clrCmdRdy),
        .i_snd_resp   (sndResp),
        .i_resp       (resp),
        .o_trmt       (trmt),
        .o_tx_data    (txData),
        .i_tx_done    (txDone),
        .o_resp_sent  (respSent),
        .o_frm_err    (frmErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flagUnexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("[TB] FAIL %s: unexpected event, value %0h, expected none", name, act);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    initial begin
        forever begin
            @(negedge clk);
            if (cmdRdy && !prevRdy) begin
                if (cmdQ.size() == 0) flagUnexpected("cmd", {16'h0, cmd});
                else checkOutput("cmd", {16'h0, cmd}, {16'h0, cmdQ.pop_front()});
            end
            if (frmErr) begin
                if (frmQ.size() == 0) flagUnexpected("frm_err", {16'h0, cmd});
                else checkOutput("frm_err_cmd_hold", {16'h0, cmd}, {16'h0, frmQ.pop_front()});
            end
            if (trmt) begin
                if (txQ.size() == 0) flagUnexpected("trmt", {24'h0, txData});
                else checkOutput("tx_data", {24'h0, txData}, {24'h0, txQ.pop_front()});
            end
            if (respSent && !prevSent) begin
                if (sentQ.size() == 0) flagUnexpected("resp_sent", {24'h0, txData});
                else checkOutput("resp_sent_data", {24'h0, txData}, {24'h0, sentQ.pop_front()});
            end
            prevRdy  = cmdRdy;
            prevSent = respSent;
        end
    end

    // One byte, presented for one cycle; returns 1 time unit after the sampling edge.
    task automatic applyStimulus(input logic [7:0] b, input logic clr);
        @(posedge clk);
        #1;
        rxRdy     = 1'b1;
        rxData    = b;
        clrCmdRdy = clr;
        #1;
        checkOutput("clr_rx_rdy", {31'h0, clrRxRdy}, 32'h1);
        @(posedge clk);
        #1;
        rxRdy     = 1'b0;
        clrCmdRdy = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic sendCmd(input logic [7:0] hi, input logic [7:0] lo, input int gap, input logic clr);
`ifdef CMD_CHKSUM_EN
        logic [7:0] ck;
        ck = hi + lo;
        ck = ~ck;
`endif
        applyStimulus(hi, 1'b0);
        idle(gap);
`ifdef CMD_CHKSUM_EN
        applyStimulus(lo, 1'b0);
        applyStimulus(ck, clr);
`else
        applyStimulus(lo, clr);
`endif
        checkOutput("cmd_rdy_latency", {31'h0, cmdRdy}, 32'h1);
    endtask

    task automatic pulseResp(input logic [7:0] r);
        @(posedge clk);
        #1;
        sndResp = 1'b1;
        resp    = r;
        @(posedge clk);
        #1;
        sndResp = 1'b0;
    endtask

    task automatic pulseTxDone();
        @(posedge clk);
        #1;
        txDone = 1'b1;
        @(posedge clk);
        #1;
        txDone = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_cmd"},       {16'h0, cmd},      32'h0);
        checkOutput({tag, "_cmd_rdy"},   {31'h0, cmdRdy},   32'h0);
        checkOutput({tag, "_trmt"},      {31'h0, trmt},     32'h0);
        checkOutput({tag, "_tx_data"},   {24'h0, txData},   32'h0);
        checkOutput({tag, "_resp_sent"}, {31'h0, respSent}, 32'h0);
        checkOutput({tag, "_frm_err"},   {31'h0, frmErr},   32'h0);
    endtask

    initial begin
        rstN = 1'b0; rxRdy = 1'b0; rxData = 8'h00; clrCmdRdy = 1'b0;
        sndResp = 1'b0; resp = 8'h00; txDone = 1'b0;
        idle(3);
        #1;
        checkAllZero("reset");
        checkOutput("reset_clr_rx_rdy", {31'h0, clrRxRdy}, 32'h0);
        rstN = 1'b1;

        $display("[TB] basic frame 3C5A");
        cmdQ.push_back(16'h3C5A);
        sendCmd(8'h3C, 8'h5A, 10, 1'b0);

        $display("[TB] inter-byte timeout");
        frmQ.push_back(16'h3C5A);
        applyStimulus(8'h12, 1'b0);
        idle(20);
        #1;
        checkOutput("timeout_cmd_rdy", {31'h0, cmdRdy}, 32'h0);
        checkOutput("timeout_cmd_hold", {16'h0, cmd}, 32'h3C5A);
        cmdQ.push_back(16'hABCD);
        sendCmd(8'hAB, 8'hCD, 2, 1'b0);

        $display("[TB] low byte on terminal count");
        cmdQ.push_back(16'h9ABC);
        sendCmd(8'h9A, 8'hBC, TIMEOUT - 2, 1'b0);

        $display("[TB] low byte one cycle late");
        frmQ.push_back(16'h9ABC);
        applyStimulus(8'h55, 1'b0);
        idle(TIMEOUT - 1);
        cmdQ.push_back(16'h6677);
        sendCmd(8'h66, 8'h77, 3, 1'b0);

        $display("[TB] set beats clear");
        cmdQ.push_back(16'h4455);
        sendCmd(8'h44, 8'h55, 2, 1'b1);
        checkOutput("set_wins", {31'h0, cmdRdy}, 32'h1);
        @(posedge clk); #1; clrCmdRdy = 1'b1;
        @(posedge clk); #1; clrCmdRdy = 1'b0;
        checkOutput("clr_cmd_rdy", {31'h0, cmdRdy}, 32'h0);

        $display("[TB] response transmit");
        txQ.push_back(8'hA5);
        pulseResp(8'hA5);
        idle(3);
        #1;
        checkOutput("resp_sent_busy", {31'h0, respSent}, 32'h0);
        pulseResp(8'h3C);
        idle(2);
        #1;
        checkOutput("tx_data_hold", {24'h0, txData}, 32'hA5);
        sentQ.push_back(8'hA5);
        pulseTxDone();
        idle(1);
        #1;
        checkOutput("resp_sent", {31'h0, respSent}, 32'h1);
        txQ.push_back(8'h5A);
        pulseResp(8'h5A);
        checkOutput("resp_sent_cleared", {31'h0, respSent}, 32'h0);

        $display("[TB] reset mid-transmit");
        idle(2);
        #1;
        rstN = 1'b0;
        idle(2);
        #1;
        checkAllZero("tx_reset");
        rstN = 1'b1;
        pulseTxDone();
        idle(1);
        #1;
        checkOutput("tx_reset_no_sent", {31'h0, respSent}, 32'h0);

        $display("[TB] reset mid-frame");
        cmdQ.push_back(16'h1122);
        sendCmd(8'h11, 8'h22, 1, 1'b0);
        applyStimulus(8'h77, 1'b0);
        rstN = 1'b0;
        idle(2);
        #1;
        checkAllZero("rx_reset");
        rstN = 1'b1;
        cmdQ.push_back(16'h0102);
        sendCmd(8'h01, 8'h02, 3, 1'b0);

`ifdef CMD_CHKSUM_EN
        $display("[TB] checksum frames");
        cmdQ.push_back(16'h1020);
        sendCmd(8'h10, 8'h20, 2, 1'b0);
        checkOutput("chk_cmd", {16'h0, cmd}, 32'h1020);
        frmQ.push_back(16'h1020);
        applyStimulus(8'h10, 1'b0);
        applyStimulus(8'h20, 1'b0);
        applyStimulus(8'hCE, 1'b0);
        idle(2);
        #1;
        checkOutput("chk_bad_cmd_hold", {16'h0, cmd}, 32'h1020);
        checkOutput("chk_bad_cmd_rdy", {31'h0, cmdRdy}, 32'h0);
`endif

        for (int i = 0; i < 50; i++) begin
            if (cmdQ.size() == 0 && frmQ.size() == 0 && txQ.size() == 0 && sentQ.size() == 0) break;
            @(posedge clk);
        end
        idle(2);
        checkOutput("pending_cmd",  cmdQ.size(),  32'h0);
        checkOutput("pending_frm",  frmQ.size(),  32'h0);
        checkOutput("pending_tx",   txQ.size(),   32'h0);
        checkOutput("pending_sent", sentQ.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
